fb_writer: RTL and testbench

Framebuffer writer: the write-side counterpart of the VGA scan-out path. It accepts a 32-bit pixel stream with start-of-frame marking, buffers pixels in a small FIFO, and writes each one as a single Wishbone classic write into the SDRAM framebuffer at the raster-order address. It shares the SDRAM port with the VGA reader through the same `token` arbitration signal.

---
 rtl/fb_pkg.sv | 11 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/fb_writer.sv | 127 ++++++++++++
 tb/tb_fb_writer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer writer.
package fb_pkg;
  localparam int PIX_W = 32;

  typedef enum logic {S_SYNC, S_RUN} in_state_t;
  typedef enum logic {B_IDLE, B_REQ} bus_state_t;

  function automatic int idx_width(input int h, input int v);
    return (h * v < 2) ? 1 : $clog2(h * v);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; contents clear on reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Full blocks a push even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fb_writer.sv
// Pixel stream to SDRAM framebuffer writer: raster-order single Wishbone writes,
// gated by the shared arbitration token.
module fb_writer
  import fb_pkg::*;
#(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             token,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_data,
  output logic             wshb_cyc,
  output logic             wshb_stb,
  output logic             wshb_we,
  output logic [3:0]       wshb_sel,
  output logic [31:0]      wshb_adr,
  output logic [31:0]      wshb_dat_ms,
  output logic [2:0]       wshb_cti,
  output logic [1:0]       wshb_bte,
  input  logic             wshb_ack,
  output logic             frame_done,
  output logic             sof_err
);
  localparam int              IDX_W    = idx_width(HDISP, VDISP);
  localparam int              FW       = IDX_W + PIX_W;
  localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDISP * VDISP - 1);

  in_state_t        in_state_q, in_state_d;
  bus_state_t       bus_state_q, bus_state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sof_err_q, sof_err_d;
  logic             frame_done_q, frame_done_d;

  logic             push, pop, full, empty, accept;
  logic [FW-1:0]    fifo_wdata, fifo_rdata;
  logic [CW-1:0]    count;
  logic [IDX_W-1:0] head_idx;

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_idx = fifo_rdata[FW-1:PIX_W];

  // Input side: drop beats until the first SOF, then tag each beat with its raster index.
  always_comb begin
    in_state_d = in_state_q;
    idx_d      = idx_q;
    sof_err_d  = 1'b0;
    push       = 1'b0;
    fifo_wdata = {idx_q, pix_data};
    pix_ready  = (in_state_q == S_SYNC) ? 1'b1 : !full;
    accept     = pix_valid && pix_ready;
    if (accept) begin
      if (pix_sof) begin
        push       = 1'b1;
        fifo_wdata = {{IDX_W{1'b0}}, pix_data};
        idx_d      = IDX_W'(1);
        in_state_d = S_RUN;
        sof_err_d  = (in_state_q == S_RUN) && (idx_q != '0);
      end else if (in_state_q == S_RUN) begin
        push  = 1'b1;
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Bus side: once started, a request holds until ack regardless of token.
  always_comb begin
    bus_state_d  = bus_state_q;
    pop          = 1'b0;
    frame_done_d = 1'b0;
    case (bus_state_q)
      B_IDLE: if (!empty && token) bus_state_d = B_REQ;
      B_REQ: begin
        if (wshb_ack) begin
          pop          = 1'b1;
          frame_done_d = (head_idx == LAST_IDX);
          if (!(count > CW'(1) && token)) bus_state_d = B_IDLE;
        end
      end
      default: bus_state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q   <= S_SYNC;
      bus_state_q  <= B_IDLE;
      idx_q        <= '0;
      sof_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      in_state_q   <= in_state_d;
      bus_state_q  <= bus_state_d;
      idx_q        <= idx_d;
      sof_err_q    <= sof_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wshb_stb    = (bus_state_q == B_REQ);
  assign wshb_cyc    = wshb_stb;
  assign wshb_we     = 1'b1;
  assign wshb_sel    = 4'b1111;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;
  assign wshb_adr    = BASE_ADDR + 32'({head_idx, 2'b00});
  assign wshb_dat_ms = fifo_rdata[PIX_W-1:0];
  assign frame_done  = frame_done_q;
  assign sof_err     = sof_err_q;
endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer using a small 16x4 frame so a whole frame fits in a short run.
module tb_fb_writer;
  localparam int          H    = 16;
  localparam int          V    = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] LAST_ADR = BASE + 32'h0000_00FC;

  logic        clk, rst_n, token, pix_valid, pix_ready, pix_sof;
  logic [31:0] pix_data;
  logic        wshb_cyc, wshb_stb, wshb_we, wshb_ack, frame_done, sof_err;
  logic [3:0]  wshb_sel;
  logic [31:0] wshb_adr, wshb_dat_ms;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic        ack_en;

  int n_chk = 0, n_fail = 0;
  int stb_cnt = 0, fd_cnt = 0, fd_bad = 0;
  logic fd_arm = 1'b0;
  logic [31:0] wq_adr[$];
  logic [31:0] wq_dat[$];

  fb_writer #(.HDISP(H), .VDISP(V), .BASE_ADDR(BASE), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .token(token),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
    .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we), .wshb_sel(wshb_sel),
    .wshb_adr(wshb_adr), .wshb_dat_ms(wshb_dat_ms), .wshb_cti(wshb_cti), .wshb_bte(wshb_bte),
    .wshb_ack(wshb_ack), .frame_done(frame_done), .sof_err(sof_err)
  );

  // Zero-wait slave: acks in the same cycle as stb when enabled.
  assign wshb_ack = ack_en & wshb_stb;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (wshb_stb) stb_cnt <= stb_cnt + 1;
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      if (!fd_arm) fd_bad <= fd_bad + 1;
    end
    fd_arm <= wshb_stb && wshb_ack && (wshb_adr == LAST_ADR);
    if (wshb_stb && wshb_ack) begin
      wq_adr.push_back(wshb_adr);
      wq_dat.push_back(wshb_dat_ms);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_present"}, 64'(wq_adr.size() != 0), 1);
    if (wq_adr.size() != 0) begin
      chk({tag, "_adr"}, 64'(wq_adr.pop_front()), 64'(a));
      chk({tag, "_dat"}, 64'(wq_dat.pop_front()), 64'(d));
    end
  endtask

  task automatic send(input logic sof, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    while (!pix_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 64'(pix_ready), 1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int s0, acc;
    rst_n = 1'b0; token = 1'b0; ack_en = 1'b0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(pix_ready), 1);
    chk("rst_stb", 64'(wshb_stb), 0);
    chk("rst_cyc", 64'(wshb_cyc), 0);
    chk("rst_adr", 64'(wshb_adr), 64'(BASE));
    chk("rst_dat", 64'(wshb_dat_ms), 0);
    chk("rst_fdone", 64'(frame_done), 0);
    chk("rst_soferr", 64'(sof_err), 0);
    chk("const_we", 64'(wshb_we), 1);
    chk("const_sel", 64'(wshb_sel), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;
    token = 1'b1; ack_en = 1'b1;

    // Beats before any SOF are discarded
    s0 = stb_cnt;
    send(1'b0, 32'h1111_0001);
    send(1'b0, 32'h1111_0002);
    send(1'b0, 32'h1111_0003);
    idle(4);
    chk("sync_ready", 64'(pix_ready), 1);
    chk("sync_no_stb", 64'(stb_cnt - s0), 0);
    chk("sync_no_wr", 64'(wq_adr.size()), 0);

    // SOF + A, B, C: latency and back-to-back writes
    @(negedge clk);
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 32'hAAAA_0000;
    @(negedge clk);
    chk("lat_n1_stb", 64'(wshb_stb), 0);
    chk("first_sof_noerr", 64'(sof_err), 0);
    pix_sof = 1'b0; pix_data = 32'hBBBB_0001;
    @(negedge clk);
    chk("lat_n2_stb", 64'(wshb_stb), 1);
    pix_data = 32'hCCCC_0002;
    idle(6);
    chk("abc_count", 64'(wq_adr.size()), 3);
    exp_wr("wr_a", BASE,          32'hAAAA_0000);
    exp_wr("wr_b", BASE + 32'd4,  32'hBBBB_0001);
    exp_wr("wr_c", BASE + 32'd8,  32'hCCCC_0002);

    // Short frame: SOF arrives at index 5
    send(1'b0, 32'h3333_0003);
    send(1'b0, 32'h3333_0004);
    @(negedge clk);
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 32'hDDDD_0000;
    @(negedge clk);
    chk("sof_err_pulse", 64'(sof_err), 1);
    pix_sof = 1'b0; pix_data = 32'hEEEE_0001;
    @(negedge clk);
    chk("sof_err_once", 64'(sof_err), 0);
    idle(6);
    exp_wr("wr_i3", BASE + 32'h0C, 32'h3333_0003);
    exp_wr("wr_i4", BASE + 32'h10, 32'h3333_0004);
    exp_wr("wr_sof", BASE,         32'hDDDD_0000);
    exp_wr("wr_sof1", BASE + 32'h4, 32'hEEEE_0001);

    // Full 16x4 frame plus one wrapping pixel
    wq_adr.delete(); wq_dat.delete();
    s0 = stb_cnt;
    fd_cnt = 0; fd_bad = 0;
    send(1'b1, 32'hF000_0000);
    for (int i = 1; i <= H * V; i++) send(1'b0, 32'hF000_0000 + 32'(i));
    idle(10);
    chk("frame_wr_count", 64'(wq_adr.size()), 65);
    chk("frame_stb_cycles", 64'(stb_cnt - s0), 65);
    chk("frame_done_cnt", 64'(fd_cnt), 1);
    chk("frame_done_timing", 64'(fd_bad), 0);
    for (int i = 0; i <= H * V; i++)
      exp_wr($sformatf("frame_%0d", i), BASE + 32'((i % (H * V)) * 4), 32'hF000_0000 + 32'(i));

    // Slave stalls: FIFO fills after 16 beats, stb holds across token drop
    ack_en = 1'b0;
    acc = 0;
    @(negedge clk);
    pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 32'hA000_0000;
    for (int c = 0; c < 25; c++) begin
      if (pix_ready) acc++;
      @(negedge clk);
      pix_data = 32'hA000_0000 + 32'(acc);
    end
    chk("full_accepted", 64'(acc), 16);
    chk("full_ready", 64'(pix_ready), 0);
    chk("stall_stb", 64'(wshb_stb), 1);
    token = 1'b0;
    repeat (5) @(negedge clk);
    chk("tokdrop_stb", 64'(wshb_stb), 1);
    chk("tokdrop_adr", 64'(wshb_adr), 64'(BASE + 32'h4));
    chk("tokdrop_dat", 64'(wshb_dat_ms), 64'h0000_0000_A000_0000);
    chk("stall_no_wr", 64'(wq_adr.size()), 0);

    // Reset mid-transfer
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_stb", 64'(wshb_stb), 0);
    chk("rst_async_cyc", 64'(wshb_cyc), 0);
    chk("rst_async_ready", 64'(pix_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    token = 1'b1; ack_en = 1'b1;
    s0 = stb_cnt;
    send(1'b0, 32'hB000_0001);
    idle(5);
    chk("post_rst_sync_stb", 64'(stb_cnt - s0), 0);
    chk("post_rst_sync_wr", 64'(wq_adr.size()), 0);
    send(1'b1, 32'hB000_0002);
    idle(5);
    chk("post_rst_wr_count", 64'(wq_adr.size()), 1);
    exp_wr("post_rst_sof", BASE, 32'hB000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
